freq_divider_multi: RTL and testbench
=====================================

Name: freq_divider_multi

Overview:
- Multi-channel programmable frequency divider; successor to the fixed power-of-two divider used to derive slow display/scan clocks.
- Each channel has a runtime-programmable integer period, a near-50% duty output and a single-cycle tick strobe.
- Divisor updates go through a valid/ready config port and take effect only at a period boundary, so outputs never glitch.
- Sits at top level, fed by the board oscillator, driving scan, debounce and blink logic.

Parameters:
- CHANNELS, 2, number of independent divider channels (>=1).
- DIV_BITS, 22, width of each channel's divisor and counter.
- RESET_DIV, 2**DIV_BITS-1, divisor loaded into every channel at reset.

Ports:
- in_clock  input  1  source clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  CHANNELS  per-channel run enable.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config write can be accepted this cycle.
- cfg_chan  input  $clog2(CHANNELS) (min 1)  target channel.
- cfg_div  input  DIV_BITS  new divisor d; period = d+1 in_clock cycles.
- clk_out  output  CHANNELS  divided clock per channel.
- tick  output  CHANNELS  one-cycle strobe on last cycle of each period.
- pending  output  CHANNELS  shadow divisor waiting to be applied.
- sync_req  input  1  present only with PHASE_ALIGN_EN.

Behaviour:
- Reset (reset_n low, asynchronous): count[i]=0, div[i]=RESET_DIV, shadow[i]=0, pending=0. Outputs during reset: clk_out=0, tick=0, cfg_ready=0.
- All outputs derive combinationally from registered state: count, div, pending.
- Channel running (en[i]=1):
  - count[i] increments each cycle; wraps to 0 on the cycle after count==div[i].
  - tick[i]=1 exactly when count[i]==div[i].
  - clk_out[i]=1 when count[i] < ((div[i]+1)>>1). Odd periods have the high phase one cycle shorter.
- Divisor d=0: period of 1 cycle. tick[i] held at 1, clk_out[i] held at 0.
- Channel disabled (en[i]=0):
  - count[i] forced to 0 on the next edge; tick[i]=0.
  - clk_out[i] follows the counter rule from count 0.
  - Pending shadow is applied on that same edge.
- Config handshake:
  - cfg_ready = ~pending[cfg_chan] when out of reset; it depends combinationally on cfg_chan.
  - A transfer occurs when cfg_valid&cfg_ready on a rising edge: shadow[cfg_chan]<=cfg_div and pending[cfg_chan]<=1.
  - cfg_chan >= CHANNELS: cfg_ready=1, the write is accepted and discarded.
- Apply rule: on the edge where tick[i]=1 (running) or en[i]=0, if pending[i] is set, then div[i]<=shadow[i], pending[i]<=0, and count[i] restarts at 0.
- New-period timing: the new period starts with the first cycle after the boundary.
- Write and apply on the same edge: the apply takes the shadow value held before that edge. The new write is not accepted, because cfg_ready was 0 while pending was set.
- Channels are fully independent; a write to channel j never perturbs channel i.
- Reset mid-period or mid-update: pending update is lost and div returns to RESET_DIV.

Optional Feature:
- Macro FREQ_DIV_PHASE_ALIGN_EN.
- Defined:
  - Input sync_req exists. When high on an edge, every enabled channel's count<=0 on that edge. Pending updates apply on that edge.
  - tick is suppressed on a sync_req cycle unless count==div already.
  - Result: all channels share phase 0 from the next cycle.
- Undefined: sync_req port absent; channels align only via reset or en.

Test Plan:
- Reset release, CHANNELS=2, DIV_BITS=4, RESET_DIV=15, en=2'b11 -> clk_out high 8 cycles, low 8; tick every 16th cycle on both channels.
- Write ch0 d=4 mid-period at count=6 -> pending[0]=1, cfg_ready low for ch0. Period 16 completes, then period 5: clk_out high 2 cycles, low 3.
- Second write to ch0 while pending -> cfg_ready=0, no transfer. Same-cycle write to ch1 d=0 accepted -> after ch1's boundary, tick[1] constant 1 and clk_out[1]=0.
- en[0] dropped for 3 cycles with pending d=7 -> count[0]=0 and tick[0]=0 while low. After re-enable, period 8 starting from count 0.
- cfg_chan=3 with CHANNELS=2 -> cfg_ready=1, no pending bit set, no output change. Assert reset_n mid-period -> all outputs 0 immediately; RESET_DIV period resumes after release.
- FREQ_DIV_PHASE_ALIGN_EN, ch0 d=3, ch1 d=5 at arbitrary offset, pulse sync_req -> both counts 0 next cycle; first coincident ticks 12 cycles after alignment.

Source files
------------

// File: rtl/freq_divider_multi.sv
// Multi-channel programmable frequency divider with glitch-free divisor updates through a valid/ready port.
// Optional build macro FREQ_DIV_PHASE_ALIGN_EN adds the sync_req input that re-phases all enabled channels.
module freq_divider_multi #(
  parameter int                  CHANNELS  = 2,
  parameter int                  DIV_BITS  = 22,
  parameter logic [DIV_BITS-1:0] RESET_DIV = {DIV_BITS{1'b1}},
  localparam int                 CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
`ifdef FREQ_DIV_PHASE_ALIGN_EN
  input  logic                sync_req,
`endif
  input  logic                in_clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [DIV_BITS-1:0] cfg_div,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic                sync_now;
  logic [CHANNELS-1:0] chan_hit;
  logic                cfg_in_range;
  logic                cfg_fire;

`ifdef FREQ_DIV_PHASE_ALIGN_EN
  assign sync_now = sync_req;
`else
  assign sync_now = 1'b0;
`endif

  // Out-of-range channel numbers are always ready so a stray write cannot stall the port.
  assign cfg_in_range = |chan_hit;
  assign cfg_ready    = reset_n & (~cfg_in_range | ~|(chan_hit & pending));
  assign cfg_fire     = cfg_valid & cfg_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_chan
      logic [DIV_BITS-1:0] count_q, count_d;
      logic [DIV_BITS-1:0] div_q, div_d;
      logic [DIV_BITS-1:0] shadow_q, shadow_d;
      logic                pend_q, pend_d;
      logic                at_end;
      logic                boundary;
      logic                apply;
      logic                write;
      logic [DIV_BITS:0]   half;

      assign chan_hit[gi] = (cfg_chan == CHAN_W'(gi));

      always_comb begin
        count_d  = count_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        at_end   = (count_q == div_q);
        // A disabled channel sits at a permanent boundary, so pending updates land immediately.
        boundary = ~en[gi] | at_end | sync_now;
        apply    = boundary & pend_q;
        write    = cfg_fire & chan_hit[gi];

        if (boundary) begin
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end

        if (apply) begin
          div_d  = shadow_q;
          pend_d = 1'b0;
        end else if (write) begin
          pend_d = 1'b1;
        end

        if (write) begin
          shadow_d = cfg_div;
        end
      end

      always_ff @(posedge in_clock or negedge reset_n) begin
        if (!reset_n) begin
          count_q  <= '0;
          div_q    <= RESET_DIV;
          shadow_q <= '0;
          pend_q   <= 1'b0;
        end else begin
          count_q  <= count_d;
          div_q    <= div_d;
          shadow_q <= shadow_d;
          pend_q   <= pend_d;
        end
      end

      // Extra bit keeps (div+1) from wrapping at the all-ones divisor.
      assign half         = ({1'b0, div_q} + 1'b1) >> 1;
      assign clk_out[gi]  = reset_n & ({1'b0, count_q} < half);
      assign tick[gi]     = reset_n & en[gi] & (count_q == div_q);
      assign pending[gi]  = pend_q;
    end
  endgenerate

endmodule

// File: tb/tb_freq_divider_multi.sv
// Scoreboard bench for freq_divider_multi: expected period lengths/high counts are queued per channel
// and a negedge monitor measures each completed period when the DUT ticks.
module tb_freq_divider_multi;

  logic       clk;
  logic       reset_n;
  logic [2:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [3:0] cfg_div;
  logic [2:0] clk_out;
  logic [2:0] tick;
  logic [2:0] pending;
  logic       sync_req;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b1;

  freq_divider_multi #(
    .CHANNELS (3),
    .DIV_BITS (4),
    .RESET_DIV(4'd15)
  ) dut (
`ifdef FREQ_DIV_PHASE_ALIGN_EN
    .sync_req (sync_req),
`endif
    .in_clock (clk),
    .reset_n  (reset_n),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_div  (cfg_div),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int len;
    int hi;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  task automatic push(input int ch, input int len, input int hi, input int n);
    exp_t e;
    e.len = len;
    e.hi  = hi;
    repeat (n) begin
      case (ch)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic next_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: measure each enabled period; compare on every tick against the queued expectation.
  int mlen[3];
  int mhi[3];
  always @(negedge clk) begin : monitor
    exp_t e;
    bit   have;
    if (mon_on) begin
      for (int i = 0; i < 3; i++) begin
        if (!reset_n || !en[i]) begin
          mlen[i] = 0;
          mhi[i]  = 0;
        end else begin
          mlen[i]++;
          if (clk_out[i]) mhi[i]++;
          if (tick[i]) begin
            have = 1'b1;
            e.len = 0;
            e.hi  = 0;
            case (i)
              0:       if (q0.size() > 0) e = q0.pop_front(); else have = 1'b0;
              1:       if (q1.size() > 0) e = q1.pop_front(); else have = 1'b0;
              default: if (q2.size() > 0) e = q2.pop_front(); else have = 1'b0;
            endcase
            n_checks++;
            if (!have) begin
              n_fail++;
              $display("FAIL period_ch%0d: tick after len %0d high %0d, required no tick", i, mlen[i], mhi[i]);
            end else if (mlen[i] != e.len || mhi[i] != e.hi) begin
              n_fail++;
              $display("FAIL period_ch%0d: got len %0d high %0d, required len %0d high %0d",
                       i, mlen[i], mhi[i], e.len, e.hi);
            end else begin
              $display("ok   period_ch%0d: len %0d high %0d", i, mlen[i], mhi[i]);
            end
            mlen[i] = 0;
            mhi[i]  = 0;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    en        = 3'b111;
    cfg_valid = 1'b0;
    cfg_chan  = 2'd0;
    cfg_div   = 4'd0;
    sync_req  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_clk_out", clk_out, 3'b000);
    check("reset_tick", tick, 3'b000);
    check("reset_cfg_ready", cfg_ready, 1'b0);
    check("reset_pending", pending, 3'b000);

    // Hand-derived periods up to the mid-run reset at cycle 50.
    push(0, 16, 8, 1);
    push(0, 5, 2, 2);
    push(0, 8, 4, 2);
    push(1, 16, 8, 1);
    push(1, 1, 0, 34);
    push(2, 16, 8, 3);

    reset_n = 1'b1;                                  // cycle 0, count 0
    #1 check("ready_after_release", cfg_ready, 1'b1);

    next_cyc(6);                                     // cycle 6: write ch0 d=4
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 4'd4;
    #1 check("ready_ch0_idle", cfg_ready, 1'b1);

    next_cyc(1);                                     // cycle 7: retry ch0 while pending
    cfg_div = 4'd9;
    #1 check("pending_after_write", pending, 3'b001);
    check("ready_ch0_pending", cfg_ready, 1'b0);

    next_cyc(1);                                     // cycle 8: write ch1 d=0
    check("pending_no_second", pending, 3'b001);
    cfg_chan = 2'd1; cfg_div = 4'd0;
    #1 check("ready_ch1", cfg_ready, 1'b1);

    next_cyc(1);                                     // cycle 9
    cfg_valid = 1'b0;
    #1 check("pending_both", pending, 3'b011);

    next_cyc(7);                                     // cycle 16: both applied at cycle-15 boundary
    check("pending_applied", pending, 3'b000);
    check("d0_tick_c16", tick[1], 1'b1);
    check("d0_clk_c16", clk_out[1], 1'b0);
    next_cyc(1);
    check("d0_tick_c17", tick[1], 1'b1);
    check("d0_clk_c17", clk_out[1], 1'b0);

    next_cyc(9);                                     // cycle 26: write ch0 d=7
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 4'd7;
    #1 check("ready_ch0_d7", cfg_ready, 1'b1);

    next_cyc(1);                                     // cycle 27: disable ch0
    cfg_valid = 1'b0;
    en = 3'b110;
    #1 check("pending_d7", pending, 3'b001);
    check("dis_tick_c27", tick[0], 1'b0);

    next_cyc(1);                                     // cycle 28
    check("dis_pending_applied", pending, 3'b000);
    check("dis_tick_c28", tick[0], 1'b0);
    check("dis_clk_c28", clk_out[0], 1'b1);

    next_cyc(2);                                     // cycle 30: re-enable
    en = 3'b111;

    next_cyc(10);                                    // cycle 40: out-of-range channel write
    cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_div = 4'd2;
    #1 check("ready_out_of_range", cfg_ready, 1'b1);

    next_cyc(1);                                     // cycle 41
    cfg_valid = 1'b0;
    cfg_chan  = 2'd0;
    #1 check("pending_out_of_range", pending, 3'b000);

    next_cyc(9);                                     // cycle 50: reset mid-period
    reset_n = 1'b0;
    #1 check("midreset_clk_out", clk_out, 3'b000);
    check("midreset_tick", tick, 3'b000);
    check("midreset_cfg_ready", cfg_ready, 1'b0);
    check("midreset_pending", pending, 3'b000);

    push(0, 16, 8, 2);
    push(1, 16, 8, 2);
    push(2, 16, 8, 2);
    next_cyc(2);
    reset_n = 1'b1;                                  // cycle 0 after release

    next_cyc(35);
    check("left_ch0", q0.size(), 0);
    check("left_ch1", q1.size(), 0);
    check("left_ch2", q2.size(), 0);

`ifdef FREQ_DIV_PHASE_ALIGN_EN
    mon_on = 1'b0;
    en = 3'b000;
    cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_div = 4'd3;
    next_cyc(1);
    cfg_chan = 2'd1; cfg_div = 4'd5;
    next_cyc(1);
    cfg_valid = 1'b0;
    next_cyc(1);
    en = 3'b001;
    next_cyc(2);
    en = 3'b011;
    next_cyc(3);
    sync_req = 1'b1;
    next_cyc(1);
    sync_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("align_tick_k%0d", k), tick[1:0], {(k % 6) == 5, (k % 4) == 3});
      next_cyc(1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
